// File: rtl/proc_cycle_seq_pkg.sv
// Shared definitions for the DaVinci instruction-cycle sequencer:
// state encodings, state width and the default memory timeout.
package prj_definition;

   localparam int STATE_W         = 3;
   localparam int DEFAULT_TIMEOUT = 16;

   // Code 6 is deliberately absent; the sequencer treats it as a fault.
   typedef enum logic [STATE_W-1:0] {
      STATE_IDLE   = 3'd0,
      STATE_FETCH  = 3'd1,
      STATE_DECODE = 3'd2,
      STATE_EXE    = 3'd3,
      STATE_MEM    = 3'd4,
      STATE_WB     = 3'd5,
      STATE_HALT   = 3'd7
   } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts not-ready cycles of the current memory request and flags the
// last allowed cycle so the sequencer can abort a hung request.
module mem_wait_timer
   import prj_definition::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] waitCount;

   // Restart on every state change; count only while memory stalls, and
   // stop at the limit because the sequencer leaves the state right after.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         waitCount <= '0;
      end else if (enable && !expired) begin
         waitCount <= waitCount + 1'b1;
      end
   end

   assign expired = (waitCount == CW'(TIMEOUT - 1));

endmodule

// File: rtl/proc_cycle_seq.sv
// Instruction-cycle sequencer: walks each instruction through
// FETCH/DECODE/EXE/MEM/WB and drives the one-cycle load/write strobes.
module proc_cycle_seq
   import prj_definition::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               MEM_READY,
   input  logic               NEEDS_MEM_READ,
   input  logic               NEEDS_MEM_WRITE,
   input  logic               WRITES_RF,
   input  logic               HALT_REQ,
   output logic [STATE_W-1:0] STATE,
   output logic               IR_LOAD,
   output logic               PC_LOAD,
   output logic               RF_WRITE,
   output logic               MEM_READ,
   output logic               MEM_WRITE,
   output logic               HALTED,
   output logic               ERR,
   output logic [CNT_W-1:0]   CYCLE_CNT,
   output logic [CNT_W-1:0]   INSTR_CNT
);

   state_t state;
   state_t stateNext;
   logic   rd_f;
   logic   wr_f;
   logic   wb_f;
   logic   errSet;
   logic   retire;
   logic   waitClear;
   logic   waitEnable;
   logic   waitExpired;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) waitTimer (
      .clock   (CLK),
      .reset   (RESET),
      .clear   (waitClear),
      .enable  (waitEnable),
      .expired (waitExpired)
   );

   // Any state change starts a fresh wait window, so re-entering FETCH
   // straight from MEM still gets the full timeout budget.
   assign waitClear  = (stateNext != state);
   assign waitEnable = ((state == STATE_FETCH) || (state == STATE_MEM)) && !MEM_READY;

   // Next-state logic; a ready response in the last allowed cycle beats the timeout.
   always_comb begin
      stateNext = state;
      errSet    = 1'b0;
      retire    = 1'b0;
      case (state)
         STATE_IDLE: stateNext = STATE_FETCH;
         STATE_FETCH: begin
            if (MEM_READY) begin
               stateNext = STATE_DECODE;
            end else if (waitExpired) begin
               stateNext = STATE_HALT;
               errSet    = 1'b1;
            end
         end
         STATE_DECODE: begin
            if (HALT_REQ) begin
               stateNext = STATE_HALT;
            end else if (NEEDS_MEM_READ && NEEDS_MEM_WRITE) begin
               stateNext = STATE_HALT;
               errSet    = 1'b1;
            end else begin
               stateNext = STATE_EXE;
            end
         end
         STATE_EXE: begin
            if (rd_f || wr_f) begin
               stateNext = STATE_MEM;
            end else if (wb_f) begin
               stateNext = STATE_WB;
            end else begin
               stateNext = STATE_FETCH;
               retire    = 1'b1;
            end
         end
         STATE_MEM: begin
            if (MEM_READY) begin
               if (wb_f) begin
                  stateNext = STATE_WB;
               end else begin
                  stateNext = STATE_FETCH;
                  retire    = 1'b1;
               end
            end else if (waitExpired) begin
               stateNext = STATE_HALT;
               errSet    = 1'b1;
            end
         end
         STATE_WB: begin
            stateNext = STATE_FETCH;
            retire    = 1'b1;
         end
         STATE_HALT: stateNext = STATE_HALT;
         default: begin
            stateNext = STATE_HALT;
            errSet    = 1'b1;
         end
      endcase
   end

   // State register plus the decode flags captured while in DECODE.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= STATE_IDLE;
         rd_f  <= 1'b0;
         wr_f  <= 1'b0;
         wb_f  <= 1'b0;
         ERR   <= 1'b0;
      end else begin
         state <= stateNext;
         if (state == STATE_DECODE) begin
            rd_f <= NEEDS_MEM_READ;
            wr_f <= NEEDS_MEM_WRITE;
            wb_f <= WRITES_RF;
         end
         if (errSet) begin
            ERR <= 1'b1;
         end
      end
   end

   // Cycle count freezes once halted; instruction count steps on retirement.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         CYCLE_CNT <= '0;
         INSTR_CNT <= '0;
      end else begin
         if (state != STATE_HALT) begin
            CYCLE_CNT <= CYCLE_CNT + 1'b1;
         end
         if (retire) begin
            INSTR_CNT <= INSTR_CNT + 1'b1;
         end
      end
   end

   assign STATE     = state;
   assign IR_LOAD   = (state == STATE_FETCH) && MEM_READY;
   assign PC_LOAD   = (state == STATE_EXE);
   assign RF_WRITE  = (state == STATE_WB);
   assign MEM_READ  = (state == STATE_FETCH) || ((state == STATE_MEM) && rd_f);
   assign MEM_WRITE = (state == STATE_MEM) && wr_f;
   assign HALTED    = (state == STATE_HALT);

endmodule

// File: doc/proc_cycle_seq.md
Name: proc_cycle_seq

Overview:
- Instruction-cycle sequencer for the DaVinci processor.
- Walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Generates the one-cycle load/write strobes consumed directly downstream: IR_LOAD to the instruction REG32, PC_LOAD to the program-counter REG32_PP, RF_WRITE to the register file, MEM_READ/MEM_WRITE to memory.
- Owns the memory-ready handshake, memory timeout detection, halt handling and cycle/instruction counters.

Parameters:
- CNT_W, 32, width of CYCLE_CNT and INSTR_CNT.
- TIMEOUT, 16, maximum number of cycles a memory request waits for MEM_READY before the error halt (must be >= 1).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- MEM_READY  in  1  memory completion for the current read/write request.
- NEEDS_MEM_READ  in  1  decoded instruction loads from memory; valid in DECODE.
- NEEDS_MEM_WRITE  in  1  decoded instruction stores to memory; valid in DECODE.
- WRITES_RF  in  1  decoded instruction writes the register file; valid in DECODE.
- HALT_REQ  in  1  decoded halt instruction; valid in DECODE.
- STATE  out  3  current state encoding.
- IR_LOAD  out  1  load strobe to the instruction register.
- PC_LOAD  out  1  load strobe to the program counter.
- RF_WRITE  out  1  register-file write strobe.
- MEM_READ  out  1  memory read request.
- MEM_WRITE  out  1  memory write request.
- HALTED  out  1  sequencer halted; sticky.
- ERR  out  1  halt caused by a fault; sticky.
- CYCLE_CNT  out  CNT_W  clock cycles since reset.
- INSTR_CNT  out  CNT_W  instructions retired since reset.

Behaviour:
- **Reset:** RESET=1 at a rising edge forces STATE=IDLE, the latched decode flags to 0, the wait counter to 0, CYCLE_CNT=0, INSTR_CNT=0, HALTED=0 and ERR=0. This applies regardless of current state, including mid-request. All strobes are decoded from state, so they are 0 in the cycle after that edge.
- **State encoding:** IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5, HALT=7. Code 6 is unused; if reached, the next state is HALT with ERR=1.
- **IDLE:** goes to FETCH on the next edge.
- **FETCH:**
  - MEM_READ=1 throughout.
  - IR_LOAD = MEM_READY. It is combinational, so IR_LOAD is high exactly in the cycle MEM_READY is seen.
  - Goes to DECODE when MEM_READY=1; otherwise stays in FETCH.
- **DECODE:**
  - Latches NEEDS_MEM_READ, NEEDS_MEM_WRITE and WRITES_RF into rd_f, wr_f and wb_f.
  - HALT_REQ=1 goes to HALT with ERR=0. HALT_REQ has priority over the illegal check.
  - NEEDS_MEM_READ=1 together with NEEDS_MEM_WRITE=1 is illegal and goes to HALT with ERR=1.
  - Otherwise goes to EXE.
- **EXE:**
  - PC_LOAD=1 for this single cycle.
  - Goes to MEM if rd_f or wr_f is set.
  - Otherwise goes to WB if wb_f is set.
  - Otherwise goes to FETCH and retires the instruction.
- **MEM:**
  - MEM_READ=rd_f and MEM_WRITE=wr_f, held until MEM_READY=1.
  - On MEM_READY, goes to WB if wb_f is set; otherwise goes to FETCH and retires.
- **WB:** RF_WRITE=1 for one cycle, then goes to FETCH and retires.
- **HALT:** all strobes 0 and HALTED=1. The state is absorbing; only RESET leaves it.
- **Memory timeout:**
  - A wait counter clears on entry to FETCH or MEM and increments each cycle MEM_READY=0 in those states.
  - When the counter reaches TIMEOUT-1 with MEM_READY still 0, the next state is HALT with ERR=1.
  - With TIMEOUT=16, a request may see at most 16 not-ready cycles.
  - MEM_READY=1 in the final allowed cycle wins over the timeout.
- **Retirement:** INSTR_CNT increments on any transition into FETCH from EXE, MEM or WB. Both counters wrap modulo 2^CNT_W.
- **CYCLE_CNT:** increments every non-reset cycle, including IDLE. It freezes in HALT.
- **Out-of-window inputs:** MEM_READY is ignored outside FETCH and MEM. Decode inputs are ignored outside DECODE.

Decomposition:
- Shared package `prj_definition`, holding:
  - state encodings: STATE_IDLE, STATE_FETCH, STATE_DECODE, STATE_EXE, STATE_MEM, STATE_WB, STATE_HALT;
  - the STATE width constant;
  - the default TIMEOUT.
- One natural sub-module, `mem_wait_timer`: the wait counter with clear/enable inputs and an expired output, reused for FETCH and MEM.
- Strobe decode and next-state logic stay in the top level.

Test Plan:
1. Reset for 2 cycles, MEM_READY tied to 1, instruction with WRITES_RF=1 and no memory access → STATE sequence 0,1,2,3,5,1; IR_LOAD, PC_LOAD and RF_WRITE each high exactly once; INSTR_CNT=1 after 5 post-reset cycles.
2. Load instruction (NEEDS_MEM_READ=1, WRITES_RF=1), MEM_READY low for 3 cycles in MEM → MEM_READ high for 4 MEM cycles, then WB with RF_WRITE=1; INSTR_CNT=1; CYCLE_CNT=9 at return to FETCH.
3. Store (NEEDS_MEM_WRITE=1, WRITES_RF=0) → MEM_WRITE high only in MEM, no RF_WRITE, returns to FETCH from MEM.
4. MEM_READY held 0 in FETCH, TIMEOUT=16 → FETCH for exactly 16 cycles, then STATE=7, HALTED=1, ERR=1; repeat with MEM_READY=1 on the 16th cycle → DECODE, ERR=0.
5. Both HALT_REQ=0 with NEEDS_MEM_READ=NEEDS_MEM_WRITE=1 in DECODE → HALT with ERR=1. HALT_REQ=1 → HALT with ERR=0; CYCLE_CNT frozen for 10 further cycles.
6. RESET asserted for one edge while in MEM with MEM_READ=1 → next cycle STATE=0, all strobes 0, counters 0, HALTED=0; normal fetch resumes.
